star_row_sched: RTL and testbench

- Top-level sequencer for the STAR softmax datapath. Processes a SEQ_LEN x SEQ_LEN score matrix one row at a time.
- Per row it drives these phases in order: CAMSUB (load and max-find), FindSub (subtract max), EXP (LUT lookup plus sum accumulate), then result drain with a valid/ready handshake.
- Sits between the input memory, the CAMSUB/CAM/LUT memories and the result consumer. Raises finish after the last row.

---
 rtl/star_pkg.sv | 39 +++
 rtl/star_delay_line.sv | 41 ++++
 rtl/star_row_sched.sv | 202 ++++++++++++++++++++
 tb/tb_star_row_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared types and constants for the STAR softmax row scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scheduler state enum, default row geometry and phase lengths,
// and a helper giving the cycle cost of one row.
`ifndef STAR_Input_len
`define STAR_Input_len 4
`endif

package star_pkg;

    // Column/row address width; the row length is the full address range.
    localparam int STAR_ADDR_W  = `STAR_Input_len;
    localparam int STAR_SEQ_LEN = 1 << STAR_ADDR_W;
    localparam int STAR_EXP_LAT = 1;

    // Per-row phase lengths (cycles) for the default geometry.
    localparam int STAR_LOAD_CYCLES    = STAR_SEQ_LEN;
    localparam int STAR_FINDSUB_CYCLES = STAR_SEQ_LEN;
    localparam int STAR_EXP_CYCLES     = STAR_SEQ_LEN;
    localparam int STAR_OUT_CYCLES     = STAR_SEQ_LEN;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FINDSUB = 3'd2,
        ST_EXP     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_OUT     = 3'd5,
        ST_DONE    = 3'd6
    } star_sched_state_t;

    // Cycles per row with an always-ready consumer.
    function automatic int star_row_cycles(input int seq_len, input int exp_lat);
        return 4 * seq_len + exp_lat;
    endfunction

endpackage

// File: rtl/star_delay_line.sv
// EXP_LAT-stage 1-bit shift register that turns exp_req into acc_en.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; a synchronous flush clears every stage in one cycle.
//
// Ports: clk, rst (async active-low), flush (sync clear), din, dout.
module star_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (flush) begin
            sr_d = '0;
        end else begin
            sr_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/star_row_sched.sv
// Row sequencer for the STAR softmax datapath: LOAD, FINDSUB, EXP, DRAIN, OUT per row.
// Latency: 4*SEQ_LEN + EXP_LAT cycles per row with out_ready held high.
// Backpressure: OUT holds address and out_valid until out_ready; abort wins over everything.
//
// Ports: clk, rst (async active-low), start, abort, out_ready in;
//        busy, data_req, data_addr_x/y, camsub_req, findsub_req, exp_req,
//        acc_clr, acc_en, out_valid, finish out.
module star_row_sched
    import star_pkg::*;
#(
    parameter int SEQ_LEN = STAR_SEQ_LEN,
    parameter int ADDR_W  = STAR_ADDR_W,
    parameter int EXP_LAT = STAR_EXP_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr_x,
    output logic [ADDR_W-1:0] data_addr_y,
    output logic              camsub_req,
    output logic              findsub_req,
    output logic              exp_req,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              finish
);

    // Terminal counts are compared directly so SEQ_LEN may fill the whole
    // address range without relying on counter overflow.
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(SEQ_LEN - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(SEQ_LEN - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(EXP_LAT - 1);

    star_sched_state_t state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [2:0]        drain_q, drain_d;

    logic              busy_q, busy_d;
    logic              load_q, load_d;
    logic              findsub_q, findsub_d;
    logic              exp_q, exp_d;
    logic              acc_clr_q, acc_clr_d;
    logic              out_valid_q, out_valid_d;
    logic              finish_q, finish_d;
    logic [ADDR_W-1:0] addr_x_q, addr_x_d;
    logic [ADDR_W-1:0] addr_y_q, addr_y_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;

        case (state_q)
            ST_IDLE: begin
                row_d = '0;
                col_d = '0;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = ST_FINDSUB;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_FINDSUB: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = ST_EXP;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_EXP: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last exp_req is still in the delay line; hold off the
                // drain until its acc_en pulse has been issued.
                if (drain_q == DRAIN_LAST) begin
                    col_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_OUT: begin
                // out_valid is always high in OUT, so out_ready alone is the handshake.
                if (out_ready) begin
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            col_d   = '0;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            drain_d = '0;
        end

        // Outputs are decoded from the next state so they line up with it.
        busy_d      = (state_d != ST_IDLE);
        load_d      = (state_d == ST_LOAD);
        findsub_d   = (state_d == ST_FINDSUB);
        exp_d       = (state_d == ST_EXP);
        acc_clr_d   = (state_d == ST_FINDSUB) && (state_q != ST_FINDSUB);
        out_valid_d = (state_d == ST_OUT);
        finish_d    = (state_d == ST_DONE);
        addr_x_d    = col_d;
        addr_y_d    = row_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            findsub_q   <= 1'b0;
            exp_q       <= 1'b0;
            acc_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
            addr_x_q    <= '0;
            addr_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            findsub_q   <= findsub_d;
            exp_q       <= exp_d;
            acc_clr_q   <= acc_clr_d;
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
            addr_x_q    <= addr_x_d;
            addr_y_q    <= addr_y_d;
        end
    end

    // acc_en trails exp_req by EXP_LAT cycles; abort flushes pulses in flight.
    star_delay_line #(
        .DEPTH (EXP_LAT)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .din   (exp_q),
        .dout  (acc_en)
    );

    assign busy        = busy_q;
    assign data_req    = load_q;
    assign camsub_req  = load_q;
    assign findsub_req = findsub_q;
    assign exp_req     = exp_q;
    assign acc_clr     = acc_clr_q;
    assign out_valid   = out_valid_q;
    assign finish      = finish_q;
    assign data_addr_x = addr_x_q;
    assign data_addr_y = addr_y_q;

endmodule

// File: tb/tb_star_row_sched.sv
// Bench for star_row_sched: two instances (EXP_LAT=1 and EXP_LAT=3, SEQ_LEN=4)
// share all inputs and are compared cycle by cycle against an expected
// timeline built from the row phase rules.
module tb_star_row_sched;

    localparam int SL   = 4;
    localparam int AW   = 2;
    localparam int MAXC = 400;

    typedef struct packed {
        logic          busy;
        logic          dreq;
        logic          creq;
        logic          freq;
        logic          ereq;
        logic          clr;
        logic          acc;
        logic          ov;
        logic          fin;
        logic [AW-1:0] ax;
        logic [AW-1:0] ay;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;

    logic          busy_o    [2];
    logic          dreq_o    [2];
    logic          creq_o    [2];
    logic          freq_o    [2];
    logic          ereq_o    [2];
    logic          clr_o     [2];
    logic          acc_o     [2];
    logic          ov_o      [2];
    logic          fin_o     [2];
    logic [AW-1:0] ax_o      [2];
    logic [AW-1:0] ay_o      [2];

    vec_t mdl [2][MAXC];
    bit   rdy [MAXC];
    int   fin_c [2];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    star_row_sched #(.SEQ_LEN(SL), .ADDR_W(AW), .EXP_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort),
        .busy(busy_o[0]), .data_req(dreq_o[0]),
        .data_addr_x(ax_o[0]), .data_addr_y(ay_o[0]),
        .camsub_req(creq_o[0]), .findsub_req(freq_o[0]), .exp_req(ereq_o[0]),
        .acc_clr(clr_o[0]), .acc_en(acc_o[0]), .out_valid(ov_o[0]),
        .out_ready(out_ready), .finish(fin_o[0])
    );

    star_row_sched #(.SEQ_LEN(SL), .ADDR_W(AW), .EXP_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort),
        .busy(busy_o[1]), .data_req(dreq_o[1]),
        .data_addr_x(ax_o[1]), .data_addr_y(ay_o[1]),
        .camsub_req(creq_o[1]), .findsub_req(freq_o[1]), .exp_req(ereq_o[1]),
        .acc_clr(clr_o[1]), .acc_en(acc_o[1]), .out_valid(ov_o[1]),
        .out_ready(out_ready), .finish(fin_o[1])
    );

    function automatic vec_t sample(input int w);
        vec_t v;
        v.busy = busy_o[w]; v.dreq = dreq_o[w]; v.creq = creq_o[w];
        v.freq = freq_o[w]; v.ereq = ereq_o[w]; v.clr = clr_o[w];
        v.acc = acc_o[w]; v.ov = ov_o[w]; v.fin = fin_o[w];
        v.ax = ax_o[w]; v.ay = ay_o[w];
        return v;
    endfunction

    // Addresses only carry meaning while a fetch/phase/result is presented.
    function automatic vec_t mask(input vec_t v, input vec_t e);
        vec_t m;
        m = v;
        if (!(e.dreq || e.ov)) m.ax = '0;
        if (!(e.dreq || e.freq || e.ereq || e.ov)) m.ay = '0;
        return m;
    endfunction

    // Expected per-cycle timeline: cycle 0 is the first LOAD cycle.
    task automatic build(input int w);
        int   t;
        int   lat;
        bit   hs;
        vec_t v;
        lat = (w == 0) ? 1 : 3;
        for (int k = 0; k < MAXC; k++) mdl[w][k] = '0;
        t = 0;
        for (int r = 0; r < SL; r++) begin
            for (int c = 0; c < SL; c++) begin
                v = '0; v.busy = 1; v.dreq = 1; v.creq = 1; v.ax = AW'(c); v.ay = AW'(r);
                mdl[w][t] = v; t++;
            end
            for (int c = 0; c < SL; c++) begin
                v = '0; v.busy = 1; v.freq = 1; v.clr = (c == 0); v.ay = AW'(r);
                mdl[w][t] = v; t++;
            end
            for (int c = 0; c < SL; c++) begin
                v = '0; v.busy = 1; v.ereq = 1; v.ay = AW'(r);
                mdl[w][t] = v; t++;
            end
            for (int d = 0; d < lat; d++) begin
                v = '0; v.busy = 1; v.ay = AW'(r);
                mdl[w][t] = v; t++;
            end
            for (int c = 0; c < SL; c++) begin
                hs = 0;
                while (!hs && t < MAXC - 8) begin
                    v = '0; v.busy = 1; v.ov = 1; v.ax = AW'(c); v.ay = AW'(r);
                    mdl[w][t] = v; hs = rdy[t]; t++;
                end
            end
        end
        v = '0; v.busy = 1; v.fin = 1;
        mdl[w][t] = v;
        fin_c[w] = t;
        // acc_en is exp_req seen lat cycles later.
        for (int k = 0; k + lat < MAXC; k++)
            if (mdl[w][k].ereq) mdl[w][k+lat].acc = 1;
    endtask

    task automatic apply_reset();
        rst_n = 0; start = 0; abort = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Runs one matrix on both instances, comparing every cycle; spot0/spot1
    // are hard finish cycles for each instance (-1 = none).
    task automatic run(input bit hold, input int spot0, input int spot1);
        vec_t g, e;
        int   last;
        build(0);
        build(1);
        last = fin_c[1] + 2;
        @(negedge clk);
        start = 1;
        out_ready = 1;
        @(posedge clk);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            start = hold;
            for (int w = 0; w < 2; w++) begin
                g = sample(w);
                e = mdl[w][k];
                if (!hold || k <= fin_c[w] + 1) begin
                    total++;
                    if (mask(g, e) !== mask(e, e)) begin
                        bad++;
                        $display("FAIL timeline lat=%0d cyc=%0d got=%h want=%h", (w == 0) ? 1 : 3, k, mask(g, e), mask(e, e));
                    end
                end else if (k == fin_c[w] + 2) begin
                    total++;
                    if (!(g.dreq === 1'b1 && g.ax === '0 && g.ay === '0)) begin
                        bad++;
                        $display("FAIL restart lat=%0d got dreq=%b ax=%0d ay=%0d want dreq=1 ax=0 ay=0", (w == 0) ? 1 : 3, g.dreq, g.ax, g.ay);
                    end
                end
                total++;
                if ($countones({g.creq, g.freq, g.ereq}) > 1 || g.dreq !== g.creq) begin
                    bad++;
                    $display("FAIL exclusive lat=%0d cyc=%0d got c/f/e/d=%b%b%b%b want onehot0 and d==c", (w == 0) ? 1 : 3, k, g.creq, g.freq, g.ereq, g.dreq);
                end
            end
            if (k == spot0) begin
                total++;
                if (fin_o[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL finish_cycle lat=1 cyc=%0d got=%b want=1", k, fin_o[0]);
                end
            end
            if (k == spot1) begin
                total++;
                if (fin_o[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL finish_cycle lat=3 cyc=%0d got=%b want=1", k, fin_o[1]);
                end
            end
            out_ready = rdy[k];
        end
        start = 0;
        out_ready = 0;
    endtask

    task automatic test_reset();
        vec_t g;
        rst_n = 0;
        #1;
        for (int w = 0; w < 2; w++) begin
            g = sample(w);
            total++;
            if (g !== '0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got=%h want=0", w, g);
            end
        end
        apply_reset();
        for (int w = 0; w < 2; w++) begin
            g = sample(w);
            total++;
            if (g !== '0) begin
                bad++;
                $display("FAIL idle_after_reset inst=%0d got=%h want=0", w, g);
            end
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        for (int k = 0; k < MAXC; k++) rdy[k] = 1;
        run(0, 68, 76);
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < MAXC; k++) rdy[k] = 1;
        rdy[15] = 0; rdy[16] = 0; rdy[17] = 0;
        run(0, 71, 79);
    endtask

    task automatic test_random_ready();
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            for (int k = 0; k < MAXC; k++) rdy[k] = ($urandom_range(0, 3) != 0);
            run(0, -1, -1);
        end
    endtask

    task automatic test_hold_start();
        apply_reset();
        for (int k = 0; k < MAXC; k++) rdy[k] = 1;
        run(1, 68, 76);
    endtask

    task automatic test_abort();
        apply_reset();
        @(negedge clk);
        start = 1;
        out_ready = 1;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 10) abort = 1;
        end
        @(negedge clk);
        abort = 0;
        for (int w = 0; w < 2; w++) begin
            total++;
            if (busy_o[w] !== 0 || ereq_o[w] !== 0 || acc_o[w] !== 0 || fin_o[w] !== 0) begin
                bad++;
                $display("FAIL abort_state inst=%0d got busy=%b exp=%b acc=%b fin=%b want all 0", w, busy_o[w], ereq_o[w], acc_o[w], fin_o[w]);
            end
        end
        repeat (5) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                total++;
                if (fin_o[w] !== 0 || busy_o[w] !== 0) begin
                    bad++;
                    $display("FAIL abort_quiet inst=%0d got fin=%b busy=%b want 0 0", w, fin_o[w], busy_o[w]);
                end
            end
        end
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        for (int w = 0; w < 2; w++) begin
            total++;
            if (dreq_o[w] !== 1 || ax_o[w] !== '0 || ay_o[w] !== '0) begin
                bad++;
                $display("FAIL abort_restart inst=%0d got dreq=%b ax=%0d ay=%0d want 1 0 0", w, dreq_o[w], ax_o[w], ay_o[w]);
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t g;
        apply_reset();
        @(negedge clk);
        start = 1;
        out_ready = 1;
        @(posedge clk);
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            start = 0;
        end
        total++;
        if (dreq_o[0] !== 1 || ay_o[0] !== 2'd2) begin
            bad++;
            $display("FAIL row2_load got dreq=%b ay=%0d want 1 2", dreq_o[0], ay_o[0]);
        end
        #2;
        rst_n = 0;
        #1;
        for (int w = 0; w < 2; w++) begin
            g = sample(w);
            total++;
            if (g !== '0) begin
                bad++;
                $display("FAIL async_reset inst=%0d got=%h want=0", w, g);
            end
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        for (int w = 0; w < 2; w++) begin
            total++;
            if (dreq_o[w] !== 1 || ay_o[w] !== '0 || ax_o[w] !== '0) begin
                bad++;
                $display("FAIL post_reset_start inst=%0d got dreq=%b ay=%0d ax=%0d want 1 0 0", w, dreq_o[w], ay_o[w], ax_o[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_random_ready();
        test_hold_start();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
